// File: rtl/ldl_rr_arbiter.sv
`timescale 1ns/1ps
// ldl_rr_arbiter
// Round-robin arbiter for N requesters with a registered one-hot grant,
// its binary index and a grant/ack handshake. A grant is held until the
// grantee acks. The ack then moves the priority pointer one past the
// grantee and re-arbitrates in the same cycle, so a new grant can follow
// with no bubble.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   en       arbitration enable (blocks new grants only)
//   req      request vector, bit i = requester i
//   ack      grantee releases the current grant (ignored while idle)
//   gnt      registered one-hot grant, zero when no grant
//   gnt_vld  a grant is outstanding
//   gnt_idx  binary index of the grantee, holds last value when idle
module ldl_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             ack,
  output logic [N-1:0]     gnt,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam int SUM_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [SUM_W-1:0] SUM_N    = SUM_W'(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
  logic [IDX_W-1:0] gnt_idx_r, gnt_idx_nxt_s;
  logic [N-1:0]     gnt_r, gnt_nxt_s;
  logic             gnt_vld_r, gnt_vld_nxt_s;
  logic [IDX_W-1:0] ack_ptr_s;
  logic [IDX_W-1:0] scan_base_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             sel_found_s;
  logic [SUM_W-1:0] cand_sum_s;
  logic [IDX_W-1:0] cand_idx_s;

  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // Pointer value one past the current grantee, wrapping N-1 to 0.
  always_comb begin
    if (gnt_idx_r == LAST_IDX) begin
      ack_ptr_s = IDX_ZERO;
    end else begin
      ack_ptr_s = gnt_idx_r + IDX_ONE;
    end
  end

  // Scan origin: on an ack the scan must already use the advanced pointer.
  always_comb begin
    if (state_r == BUSY) begin
      scan_base_s = ack_ptr_s;
    end else begin
      scan_base_s = ptr_r;
    end
  end

  // Rotating-priority search: first set req bit from scan_base_s upward, modulo N.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = IDX_ZERO;
    cand_sum_s  = {SUM_W{1'b0}};
    cand_idx_s  = IDX_ZERO;
    for (int k = 0; k < N; k++) begin
      cand_sum_s = SUM_W'(scan_base_s) + SUM_W'(k);
      if (cand_sum_s >= SUM_N) begin
        cand_sum_s = cand_sum_s - SUM_N;
      end else begin
        cand_sum_s = cand_sum_s;
      end
      cand_idx_s = cand_sum_s[IDX_W-1:0];
      if (!sel_found_s && req[cand_idx_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_idx_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Next-state and next-output logic of the grant FSM.
  always_comb begin
    state_nxt_s   = state_r;
    ptr_nxt_s     = ptr_r;
    gnt_nxt_s     = gnt_r;
    gnt_vld_nxt_s = gnt_vld_r;
    gnt_idx_nxt_s = gnt_idx_r;
    case (state_r)
      IDLE: begin
        if (en && sel_found_s) begin
          gnt_nxt_s     = to_onehot(sel_idx_s);
          gnt_idx_nxt_s = sel_idx_s;
          gnt_vld_nxt_s = 1'b1;
          state_nxt_s   = BUSY;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      BUSY: begin
        if (ack) begin
          ptr_nxt_s = ack_ptr_s;
          if (en && sel_found_s) begin
            gnt_nxt_s     = to_onehot(sel_idx_s);
            gnt_idx_nxt_s = sel_idx_s;
            gnt_vld_nxt_s = 1'b1;
            state_nxt_s   = BUSY;
          end else begin
            // gnt_idx keeps the last grantee while idle
            gnt_nxt_s     = {N{1'b0}};
            gnt_vld_nxt_s = 1'b0;
            state_nxt_s   = IDLE;
          end
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        gnt_nxt_s     = {N{1'b0}};
        gnt_vld_nxt_s = 1'b0;
        state_nxt_s   = IDLE;
      end
    endcase
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= IDX_ZERO;
      gnt_r     <= {N{1'b0}};
      gnt_vld_r <= 1'b0;
      gnt_idx_r <= IDX_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      gnt_r     <= gnt_nxt_s;
      gnt_vld_r <= gnt_vld_nxt_s;
      gnt_idx_r <= gnt_idx_nxt_s;
    end
  end

  assign gnt     = gnt_r;
  assign gnt_vld = gnt_vld_r;
  assign gnt_idx = gnt_idx_r;

endmodule

// File: tb/tb_ldl_rr_arbiter.sv
`timescale 1ns/1ps
// Bench for ldl_rr_arbiter: an N=4 and an N=5 instance share clock, reset,
// en and ack; each has its own request vector. A grant-holder model
// (busy flag, grantee, pointer) predicts every output after every edge.
module tb_ldl_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ack;
  logic [3:0] req4;
  logic [4:0] req5;
  logic [3:0] gnt4;
  logic       vld4;
  logic [1:0] idx4;
  logic [4:0] gnt5;
  logic       vld5;
  logic [2:0] idx5;

  int total_cnt;
  int bad_cnt;

  // reference model state, [0] = N=4 instance, [1] = N=5 instance
  bit m_busy [2];
  int m_idx  [2];
  int m_ptr  [2];

  ldl_rr_arbiter #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .req(req4), .ack(ack),
    .gnt(gnt4), .gnt_vld(vld4), .gnt_idx(idx4)
  );

  ldl_rr_arbiter #(.N(5)) u_dut5 (
    .clk(clk), .rst(rst), .en(en), .req(req5), .ack(ack),
    .gnt(gnt5), .gnt_vld(vld5), .gnt_idx(idx5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // first requester at or after p (circularly) that is requesting, -1 if none
  function automatic int pick(input int n, input int p, input logic [7:0] r);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_busy[u] = 1'b0;
      m_idx[u]  = 0;
      m_ptr[u]  = 0;
    end
  endtask

  task automatic model_step(input int u, input int n, input logic e, input logic [7:0] r, input logic a);
    int sel;
    if (m_busy[u] && a) begin
      m_ptr[u] = (m_idx[u] + 1) % n;
      sel = pick(n, m_ptr[u], r);
      if (e && sel >= 0) m_idx[u] = sel;
      else m_busy[u] = 1'b0;
    end else if (!m_busy[u] && e) begin
      sel = pick(n, m_ptr[u], r);
      if (sel >= 0) begin
        m_idx[u]  = sel;
        m_busy[u] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] eg4;
    logic [31:0] eg5;
    eg4 = m_busy[0] ? (32'd1 << m_idx[0]) : 32'd0;
    eg5 = m_busy[1] ? (32'd1 << m_idx[1]) : 32'd0;
    check_val("gnt4", {28'd0, gnt4}, eg4);
    check_val("vld4", {31'd0, vld4}, {31'd0, m_busy[0]});
    check_val("idx4", {30'd0, idx4}, m_idx[0]);
    check_val("gnt5", {27'd0, gnt5}, eg5);
    check_val("vld5", {31'd0, vld5}, {31'd0, m_busy[1]});
    check_val("idx5", {29'd0, idx5}, m_idx[1]);
    check_val("inv4", {31'd0, (gnt4[idx4] == vld4)}, 32'd1);
  endtask

  // one clock: drive at negedge, advance model, check just after posedge
  task automatic step(input logic e, input logic [3:0] r4, input logic [4:0] r5, input logic a);
    @(negedge clk);
    en   = e;
    req4 = r4;
    req5 = r5;
    ack  = a;
    model_step(0, 4, e, {4'd0, r4}, a);
    model_step(1, 5, e, {3'd0, r5}, a);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    en   = 1'b0;
    req4 = 4'd0;
    req5 = 5'd0;
    ack  = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_rot [5];
    total_cnt = 0;
    bad_cnt   = 0;
    rst  = 1'b1;
    en   = 1'b0;
    req4 = 4'd0;
    req5 = 5'd0;
    ack  = 1'b0;
    model_reset();
    exp_rot = '{0, 1, 2, 3, 0};

    // reset / idle, then a stray ack
    do_reset();
    repeat (10) step(1'b1, 4'b0000, 5'b00000, 1'b0);
    step(1'b1, 4'b0000, 5'b00000, 1'b1);
    step(1'b1, 4'b0000, 5'b00000, 1'b0);
    check_val("idle_vld", {31'd0, vld4}, 32'd0);

    // single grant held after req drops, released by ack
    step(1'b1, 4'b0100, 5'b00100, 1'b0);
    check_val("single_gnt", {28'd0, gnt4}, 32'h4);
    check_val("single_idx", {30'd0, idx4}, 32'd2);
    repeat (5) step(1'b1, 4'b0000, 5'b00000, 1'b0);
    check_val("single_hold", {28'd0, gnt4}, 32'h4);
    step(1'b1, 4'b0000, 5'b00000, 1'b1);
    check_val("single_rel", {31'd0, vld4}, 32'd0);

    // rotation fairness with all requesting and ack every cycle
    do_reset();
    step(1'b1, 4'b1111, 5'b11111, 1'b0);
    check_val("rot_idx", {30'd0, idx4}, exp_rot[0]);
    for (int i = 1; i < 5; i++) begin
      step(1'b1, 4'b1111, 5'b11111, 1'b1);
      check_val("rot_idx", {30'd0, idx4}, exp_rot[i]);
      check_val("rot_vld", {31'd0, vld4}, 32'd1);
    end

    // wrap and skip
    do_reset();
    step(1'b1, 4'b1000, 5'b10000, 1'b0);
    check_val("wrap_idx3", {30'd0, idx4}, 32'd3);
    check_val("wrap_idx4", {29'd0, idx5}, 32'd4);
    step(1'b1, 4'b0101, 5'b00011, 1'b1);
    check_val("skip_first", {30'd0, idx4}, 32'd0);
    check_val("wrap5_first", {29'd0, idx5}, 32'd0);
    step(1'b1, 4'b0101, 5'b00011, 1'b1);
    check_val("skip_second", {30'd0, idx4}, 32'd2);
    check_val("wrap5_second", {29'd0, idx5}, 32'd1);

    // enable gating
    do_reset();
    repeat (8) step(1'b0, 4'b1111, 5'b11111, 1'b0);
    check_val("en_block", {31'd0, vld4}, 32'd0);
    step(1'b1, 4'b1111, 5'b11111, 1'b0);
    check_val("en_grant", {30'd0, idx4}, 32'd0);
    repeat (3) step(1'b0, 4'b1111, 5'b11111, 1'b0);
    check_val("en_hold", {28'd0, gnt4}, 32'h1);
    step(1'b0, 4'b1111, 5'b11111, 1'b1);
    check_val("en_release", {31'd0, vld4}, 32'd0);

    // asynchronous reset during a grant to index 1
    do_reset();
    step(1'b1, 4'b1111, 5'b11111, 1'b0);
    step(1'b1, 4'b1111, 5'b11111, 1'b1);
    check_val("mid_pre", {30'd0, idx4}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_val("mid_gnt", {28'd0, gnt4}, 32'd0);
    check_val("mid_vld", {31'd0, vld4}, 32'd0);
    check_val("mid_idx", {30'd0, idx4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'b1111, 5'b11111, 1'b0);
    check_val("mid_after", {30'd0, idx4}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 7) != 0), 4'($urandom), 5'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
